tt_um_matmul2x2_port: RTL
=========================

// Module: tt_um_matmul2x2_port
// PURPOSE
// Pin-level responder for the 2x2 matrix-multiplier tile. An external host (bench or test equipment)
// writes eight operand bytes over ui_in with a write strobe, the block computes C = A*B with one
// shared multiplier, then returns eight result bytes on uo_out, one byte per read strobe.
// Sits directly behind the TinyTapeout user-project pin frame; top-level user module of the tile.
// PARAMETERS
// N_SYNC   2   synchronizer flops on each strobe pin (>=2)
// ACC_W    16  result width per C element before byte serialisation (fixed byte count 2)
// PORTS
// clk      in   1  system clock, single domain
// rst_n    in   1  asynchronous active-low reset
// ena      in   1  tile enable; 0 freezes all state (no captures, no compute progress)
// ui_in    in   8  operand byte from host
// uio_in   in   8  [0]=wr_stb, [1]=rd_stb (asynchronous pins); [7:2] unused
// uo_out   out  8  current result byte in UNLOAD, else 0
// uio_out  out  8  [2]=busy, [3]=done; all other bits 0
// uio_oe   out  8  constant 8'b0000_1100
// BEHAVIOUR
// - Reset (async): state LOAD, byte index 0, operand/result regs 0, uo_out=0, busy=0, done=0.
// - Strobes: each passes N_SYNC flops + rising-edge detector -> 1-cycle pulse; a level held high
//   yields exactly one pulse. ui_in sampled on the pulse cycle (N_SYNC+1 clks after pin rise);
//   host holds ui_in stable while wr_stb high.
// - LOAD: each wr pulse stores ui_in in order a00,a01,a10,a11,b00,b01,b10,b11 (unsigned 8b).
//   Cycle after 8th capture -> COMPUTE, busy=1. rd pulses ignored.
// - COMPUTE: 8 cycles, one 8x8 product/cycle; c_ij = a_i0*b_0j + a_i1*b_1j; accumulator 17b,
//   cleared per element; element order c00,c01,c10,c11. wr/rd pulses ignored.
//   After 8th cycle -> UNLOAD: busy=0, done=1, byte index 0 (done rises 9 clks after 8th capture).
// - UNLOAD: uo_out = result byte[idx], order c00[15:8],c00[7:0],c01..,c11[7:0] (MSB first).
//   Each rd pulse advances idx; uo_out updates the cycle after the pulse. 8th rd pulse -> LOAD,
//   done=0, uo_out=0, idx=0. wr pulses ignored.
// - Simultaneous wr and rd pulse: only the one legal in the current state acts.
// - ena=0: pulses dropped, COMPUTE counter holds; outputs hold values.
// - Reset mid-operation: immediate return to reset state; partial operands discarded.
// CONFIGURATION
// MATMUL_SAT_EN defined: 17b sum > 0xFFFF saturates to 0xFFFF.
// MATMUL_SAT_EN undefined: result = sum[15:0] (wraps modulo 2^16).
// STRUCTURE
// Package matmul_pkg: state enum {LOAD,COMPUTE,UNLOAD}; ELEM_W=8; N_OPND_BYTES=8;
//   N_RES_BYTES=8; N_MAC_CYCLES=8; UIO_OE_MASK=8'h0C; uio bit-index constants.
// Sub-module strobe_sync (N_SYNC synchronizer + rising-edge pulse), instanced for wr and rd.
// Top holds FSM, operand/result regs, single multiplier + accumulator, output mux.
// TESTING
// 1 Reset: rst_n=0 -> uo_out=00, uio_out=00, uio_oe=0C; release -> unchanged until strobes.
// 2 A=[[1,2],[3,4]], B=[[5,6],[7,8]] -> busy 8 clks, done=1; reads give 00 13 00 16 00 2B 00 32.
// 3 All operands FF -> each C=130050: with MATMUL_SAT_EN bytes FF FF x4; without FC 02 x4.
// 4 rd strobes in LOAD and wr strobes in UNLOAD -> no index change, uo_out/results unchanged.
// 5 wr_stb held high 20 clks -> exactly one byte captured; reset after 5 writes or mid-UNLOAD
//   -> done=0, uo_out=00; fresh case-2 load yields case-2 result.
// 6 ena=0 during COMPUTE for 10 clks -> busy stays 1, done delayed 10 clks, result correct.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared types and constants for the 2x2 matrix-multiplier tile.
package matmul_pkg;
    typedef enum logic [1:0] {LOAD, COMPUTE, UNLOAD} state_t;

    localparam int ELEM_W       = 8;
    localparam int N_OPND_BYTES = 8;
    localparam int N_RES_BYTES  = 8;
    localparam int N_MAC_CYCLES = 8;

    localparam logic [7:0] UIO_OE_MASK = 8'h0C;

    localparam int WR_BIT   = 0;
    localparam int RD_BIT   = 1;
    localparam int BUSY_BIT = 2;
    localparam int DONE_BIT = 3;
endpackage

// File: rtl/strobe_sync.sv
// Synchronises an asynchronous strobe pin and emits a one-cycle pulse on its rising edge.
module strobe_sync #(
    parameter int N_SYNC = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic pulse
);
    logic [N_SYNC-1:0] sync;
    logic              prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[N_SYNC-2:0], pin};
            prev <= sync[N_SYNC-1];
        end
    end

    assign pulse = sync[N_SYNC-1] & ~prev;
endmodule

// File: rtl/tt_um_matmul2x2_port.sv
// TinyTapeout top for the 2x2 matrix multiplier: byte-serial load, shared-multiplier compute, byte-serial unload.
// Build option: define MATMUL_SAT_EN to saturate results at 0xFFFF instead of wrapping.
module tt_um_matmul2x2_port
    import matmul_pkg::*;
#(
    parameter int N_SYNC = 2,
    parameter int ACC_W  = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    localparam int PROD_W = 2 * ELEM_W;

    state_t              state;
    logic [2:0]          idx;
    logic [2:0]          cnt;
    logic [ELEM_W-1:0]   opnd [N_OPND_BYTES];
    logic [ACC_W-1:0]    res  [4];
    logic [ACC_W:0]      acc;
    logic [7:0]          out_byte;
    logic                busy;
    logic                done;

    logic                wr_pulse;
    logic                rd_pulse;
    logic [1:0]          elem;
    logic                term;
    logic [ELEM_W-1:0]   mul_a;
    logic [ELEM_W-1:0]   mul_b;
    logic [PROD_W-1:0]   prod;
    logic [ACC_W:0]      sum;
    logic [2:0]          next_idx;
    logic                unused_pins;

    function automatic logic [ACC_W-1:0] fit_result(input logic [ACC_W:0] s);
`ifdef MATMUL_SAT_EN
        return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
`else
        return s[ACC_W-1:0];
`endif
    endfunction

    function automatic logic [7:0] sel_byte(input logic [ACC_W-1:0] r, input logic lo);
        return lo ? r[7:0] : r[ACC_W-1 -: 8];
    endfunction

    strobe_sync #(.N_SYNC(N_SYNC)) u_wr_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .pin  (uio_in[WR_BIT]),
        .pulse(wr_pulse)
    );

    strobe_sync #(.N_SYNC(N_SYNC)) u_rd_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .pin  (uio_in[RD_BIT]),
        .pulse(rd_pulse)
    );

    // Each element takes two MAC cycles: even cycle loads a_i0*b_0j, odd cycle adds a_i1*b_1j.
    assign elem     = cnt[2:1];
    assign term     = cnt[0];
    assign mul_a    = opnd[{1'b0, elem[1], term}];
    assign mul_b    = opnd[{1'b1, term, elem[0]}];
    assign prod     = {{ELEM_W{1'b0}}, mul_a} * {{ELEM_W{1'b0}}, mul_b};
    assign sum      = acc + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};
    assign next_idx = idx + 3'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= LOAD;
            idx      <= '0;
            cnt      <= '0;
            acc      <= '0;
            out_byte <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            for (int i = 0; i < N_OPND_BYTES; i++) opnd[i] <= '0;
            for (int i = 0; i < 4; i++) res[i] <= '0;
        end else if (ena) begin
            case (state)
                LOAD: begin
                    if (wr_pulse) begin
                        opnd[idx] <= ui_in;
                        idx       <= next_idx;
                        if (idx == 3'(N_OPND_BYTES - 1)) begin
                            state <= COMPUTE;
                            busy  <= 1'b1;
                            cnt   <= '0;
                        end
                    end
                end
                COMPUTE: begin
                    cnt <= cnt + 3'd1;
                    if (!term) acc <= {{(ACC_W + 1 - PROD_W){1'b0}}, prod};
                    else       res[elem] <= fit_result(sum);
                    if (cnt == 3'(N_MAC_CYCLES - 1)) begin
                        state    <= UNLOAD;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        idx      <= '0;
                        // c00 was finished on the second MAC cycle, so it is safe to present now.
                        out_byte <= sel_byte(res[0], 1'b0);
                    end
                end
                UNLOAD: begin
                    if (rd_pulse) begin
                        if (idx == 3'(N_RES_BYTES - 1)) begin
                            state    <= LOAD;
                            done     <= 1'b0;
                            out_byte <= '0;
                            idx      <= '0;
                        end else begin
                            idx      <= next_idx;
                            out_byte <= sel_byte(res[next_idx[2:1]], next_idx[0]);
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

    always_comb begin
        uio_out           = '0;
        uio_out[BUSY_BIT] = busy;
        uio_out[DONE_BIT] = done;
    end

    assign uo_out      = out_byte;
    assign uio_oe      = UIO_OE_MASK;
    assign unused_pins = &{1'b0, uio_in[7:2]};
endmodule
